// File: rtl/wb_xfer_monitor.sv
// wb_xfer_monitor
// Passive Wishbone B4 classic-cycle monitor. It taps cyc/stb/we/sel/adr/ack on
// the Wishbone clock, counts completed reads and writes (saturating), tracks
// the ack latency (last and maximum) and raises sticky protocol-error flags.
// It never drives the bus.
//
// Ports:
//   wb_clk_i, wb_rst_i     - clock, synchronous active-high reset
//   mon_cyc/stb/we/sel/adr - monitored request signals
//   mon_ack                - monitored slave acknowledge
//   clr                    - synchronous clear of counters, latencies, flags
//   wr_count, rd_count     - completed write/read transfers (saturating)
//   lat_last, lat_max      - ack latency of last transfer / maximum seen
//   busy                   - high while a request is waiting for ack
//   err_*                  - sticky protocol-error flags
module wb_xfer_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LAT_W   = 8,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned ADDR_W  = 26
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              mon_cyc,
    input  logic              mon_stb,
    input  logic              mon_we,
    input  logic [3:0]        mon_sel,
    input  logic [ADDR_W-1:0] mon_adr,
    input  logic              mon_ack,
    input  logic              clr,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [LAT_W-1:0]  lat_last,
    output logic [LAT_W-1:0]  lat_max,
    output logic              busy,
    output logic              err_ack_no_req,
    output logic              err_stb_drop,
    output logic              err_attr_chg,
    output logic              err_timeout
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                sh_we_q, sh_we_d;
    logic [3:0]          sh_sel_q, sh_sel_d;
    logic [ADDR_W-1:0]   sh_adr_q, sh_adr_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic [CNT_W-1:0]    rd_count_q, rd_count_d;
    logic [LAT_W-1:0]    lat_last_q, lat_last_d;
    logic [LAT_W-1:0]    lat_max_q, lat_max_d;
    logic                busy_q, busy_d;
    logic                e_anr_q, e_anr_d;
    logic                e_drop_q, e_drop_d;
    logic                e_attr_q, e_attr_d;
    logic                e_to_q, e_to_d;

    logic                req;
    logic                done;
    logic                done_we;
    logic [LAT_W-1:0]    done_lat;

    assign req = mon_cyc & mon_stb;

    // State and status registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            sh_we_q    <= 1'b0;
            sh_sel_q   <= '0;
            sh_adr_q   <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            lat_last_q <= '0;
            lat_max_q  <= '0;
            busy_q     <= 1'b0;
            e_anr_q    <= 1'b0;
            e_drop_q   <= 1'b0;
            e_attr_q   <= 1'b0;
            e_to_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            sh_we_q    <= sh_we_d;
            sh_sel_q   <= sh_sel_d;
            sh_adr_q   <= sh_adr_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            lat_last_q <= lat_last_d;
            lat_max_q  <= lat_max_d;
            busy_q     <= busy_d;
            e_anr_q    <= e_anr_d;
            e_drop_q   <= e_drop_d;
            e_attr_q   <= e_attr_d;
            e_to_q     <= e_to_d;
        end
    end

    // Next-state, transfer accounting and error detection
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        sh_we_d    = sh_we_q;
        sh_sel_d   = sh_sel_q;
        sh_adr_d   = sh_adr_q;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        lat_last_d = lat_last_q;
        lat_max_d  = lat_max_q;
        e_anr_d    = e_anr_q;
        e_drop_d   = e_drop_q;
        e_attr_d   = e_attr_q;
        e_to_d     = e_to_q;
        done       = 1'b0;
        done_we    = 1'b0;
        done_lat   = '0;

        // Stray ack is independent of the FSM
        if (mon_ack && !req) begin
            e_anr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mon_ack) begin
                        done     = 1'b1;
                        done_we  = mon_we;
                        done_lat = '0;
                    end else begin
                        sh_we_d   = mon_we;
                        sh_sel_d  = mon_sel;
                        sh_adr_d  = mon_adr;
                        lat_cnt_d = LAT_W'(1);
                        state_d   = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (!req) begin
                    e_drop_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    // Attributes must stay stable for the whole wait, ack cycle included
                    if ((mon_we != sh_we_q) || (mon_sel != sh_sel_q) ||
                        (mon_adr != sh_adr_q)) begin
                        e_attr_d = 1'b1;
                    end
                    if (mon_ack) begin
                        done     = 1'b1;
                        done_we  = sh_we_q;
                        done_lat = lat_cnt_q;
                        state_d  = IDLE;
                    end else if (lat_cnt_q == LAT_W'(TIMEOUT)) begin
                        e_to_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion bookkeeping; counters stick at all-ones
        if (done) begin
            lat_last_d = done_lat;
            if (done_lat > lat_max_q) begin
                lat_max_d = done_lat;
            end
            if (done_we) begin
                if (wr_count_q != {CNT_W{1'b1}}) begin
                    wr_count_d = wr_count_q + CNT_W'(1);
                end
            end else begin
                if (rd_count_q != {CNT_W{1'b1}}) begin
                    rd_count_d = rd_count_q + CNT_W'(1);
                end
            end
        end

        busy_d = (state_d == WAIT_ACK);

        // Clear overrides any same-cycle completion or error; FSM keeps running
        if (clr) begin
            wr_count_d = '0;
            rd_count_d = '0;
            lat_last_d = '0;
            lat_max_d  = '0;
            e_anr_d    = 1'b0;
            e_drop_d   = 1'b0;
            e_attr_d   = 1'b0;
            e_to_d     = 1'b0;
        end
    end

    assign wr_count       = wr_count_q;
    assign rd_count       = rd_count_q;
    assign lat_last       = lat_last_q;
    assign lat_max        = lat_max_q;
    assign busy           = busy_q;
    assign err_ack_no_req = e_anr_q;
    assign err_stb_drop   = e_drop_q;
    assign err_attr_chg   = e_attr_q;
    assign err_timeout    = e_to_q;

endmodule

// File: tb/tb_wb_xfer_monitor.sv
// Directed bench for wb_xfer_monitor. Expected status snapshots are queued
// as each step is driven and popped/compared once the step has completed.
module tb_wb_xfer_monitor;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAT_W   = 8;
    localparam int unsigned TIMEOUT = 200;
    localparam int unsigned ADDR_W  = 26;

    logic              clk = 1'b0;
    logic              rst;
    logic              mon_cyc, mon_stb, mon_we, mon_ack, clr;
    logic [3:0]        mon_sel;
    logic [ADDR_W-1:0] mon_adr;
    logic [CNT_W-1:0]  wr_count, rd_count;
    logic [LAT_W-1:0]  lat_last, lat_max;
    logic              busy, err_ack_no_req, err_stb_drop, err_attr_chg, err_timeout;

    int checks = 0;
    int errors = 0;
    int bc;

    typedef struct {
        string       tag;
        int unsigned wr;
        int unsigned rd;
        int unsigned ll;
        int unsigned lm;
        logic [3:0]  err;   // {ack_no_req, stb_drop, attr_chg, timeout}
        logic        bsy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    wb_xfer_monitor #(
        .CNT_W(CNT_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .mon_cyc(mon_cyc), .mon_stb(mon_stb), .mon_we(mon_we),
        .mon_sel(mon_sel), .mon_adr(mon_adr), .mon_ack(mon_ack), .clr(clr),
        .wr_count(wr_count), .rd_count(rd_count),
        .lat_last(lat_last), .lat_max(lat_max), .busy(busy),
        .err_ack_no_req(err_ack_no_req), .err_stb_drop(err_stb_drop),
        .err_attr_chg(err_attr_chg), .err_timeout(err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned wr, input int unsigned rd,
                        input int unsigned ll, input int unsigned lm,
                        input logic [3:0] err, input logic bsy);
        exp_t e;
        e.tag = tag; e.wr = wr; e.rd = rd; e.ll = ll; e.lm = lm; e.err = err; e.bsy = bsy;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        cmp("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".wr_count"}, 32'(wr_count), e.wr);
            cmp({e.tag, ".rd_count"}, 32'(rd_count), e.rd);
            cmp({e.tag, ".lat_last"}, 32'(lat_last), e.ll);
            cmp({e.tag, ".lat_max"},  32'(lat_max),  e.lm);
            cmp({e.tag, ".errors"},
                32'({err_ack_no_req, err_stb_drop, err_attr_chg, err_timeout}), 32'(e.err));
            cmp({e.tag, ".busy"}, 32'(busy), 32'(e.bsy));
        end
    endtask

    task automatic bus_idle();
        mon_cyc = 1'b0; mon_stb = 1'b0; mon_ack = 1'b0;
    endtask

    // One transfer with 'waits' ack-less edges after the request edge, ack on the next.
    task automatic xfer(input logic we, input logic [ADDR_W-1:0] adr, input int waits,
                        input bit hold, output int busy_cycles);
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_we = we; mon_sel = 4'hf;
        mon_adr = adr; mon_ack = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < waits; i++) begin
            tick();
            if (busy) busy_cycles++;
        end
        mon_ack = 1'b1;
        tick();
        mon_ack = 1'b0;
        if (!hold) begin
            mon_cyc = 1'b0; mon_stb = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; mon_we = 1'b0; mon_sel = 4'h0; mon_adr = '0;
        bus_idle();
        tick(); tick();
        rst = 1'b0;
        push("reset", 0, 0, 0, 0, 4'b0000, 1'b0);
        check_sb();

        // Write acked 3 cycles after stb
        push("wr3", 1, 0, 3, 3, 4'b0000, 1'b0);
        xfer(1'b1, 26'h123, 3, 1'b0, bc);
        cmp("wr3.busy_cycles", 32'(bc), 32'd3);
        check_sb();

        // Zero-wait read then 5-wait read with stb held
        push("rd0", 1, 1, 0, 3, 4'b0000, 1'b0);
        xfer(1'b0, 26'h200, 0, 1'b1, bc);
        cmp("rd0.busy_cycles", 32'(bc), 32'd0);
        check_sb();
        push("rd5", 1, 2, 5, 5, 4'b0000, 1'b0);
        xfer(1'b0, 26'h204, 5, 1'b0, bc);
        cmp("rd5.busy_cycles", 32'(bc), 32'd5);
        check_sb();

        // stb withdrawn after 2 waits, then a stray ack
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_we = 1'b1; mon_adr = 26'h240;
        tick(); tick();
        bus_idle();
        tick();
        push("drop", 1, 2, 5, 5, 4'b0100, 1'b0);
        check_sb();
        mon_ack = 1'b1;
        tick();
        mon_ack = 1'b0;
        push("ack_no_req", 1, 2, 5, 5, 4'b1100, 1'b0);
        check_sb();

        // Address change mid-wait still counts
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_we = 1'b1; mon_adr = 26'h300;
        tick(); tick();
        mon_adr = 26'h304;
        tick();
        mon_ack = 1'b1;
        tick();
        bus_idle();
        push("attr", 2, 2, 3, 5, 4'b1110, 1'b0);
        check_sb();

        // Timeout: 200 edges still waiting, 201st edge aborts
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_we = 1'b0; mon_adr = 26'h400;
        for (int i = 0; i < 200; i++) tick();
        push("to_pre", 2, 2, 3, 5, 4'b1110, 1'b1);
        check_sb();
        tick();
        push("timeout", 2, 2, 3, 5, 4'b1111, 1'b0);
        check_sb();
        bus_idle();
        tick();

        // clr coincident with ack wins
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_we = 1'b1; mon_adr = 26'h500;
        tick(); tick();
        mon_ack = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        bus_idle();
        push("clr_ack", 0, 0, 0, 0, 4'b0000, 1'b0);
        check_sb();

        // Populate state, then reset mid-wait
        push("wr0", 1, 0, 0, 0, 4'b0000, 1'b0);
        xfer(1'b1, 26'h600, 0, 1'b0, bc);
        check_sb();
        mon_ack = 1'b1;
        tick();
        mon_ack = 1'b0;
        push("anr2", 1, 0, 0, 0, 4'b1000, 1'b0);
        check_sb();
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_we = 1'b1; mon_adr = 26'h700;
        tick(); tick();
        push("pre_rst", 1, 0, 0, 0, 4'b1000, 1'b1);
        check_sb();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_idle();
        push("rst_mid", 0, 0, 0, 0, 4'b0000, 1'b0);
        check_sb();
        tick();
        push("post_rst", 0, 1, 1, 1, 4'b0000, 1'b0);
        xfer(1'b0, 26'h710, 1, 1'b0, bc);
        check_sb();

        // Saturation: 2^CNT_W+3 zero-wait writes back-to-back
        clr = 1'b1;
        tick();
        clr = 1'b0;
        push("sat_clr", 0, 0, 0, 0, 4'b0000, 1'b0);
        check_sb();
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_we = 1'b1; mon_ack = 1'b1; mon_adr = 26'h800;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (i == 15) begin
                push("sat15", 15, 0, 0, 0, 4'b0000, 1'b0);
                check_sb();
            end
        end
        bus_idle();
        push("sat19", 15, 0, 0, 0, 4'b0000, 1'b0);
        check_sb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
